dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_if.sv | 41 ++++
 rtl/dmem_responder.sv | 222 ++++++++++++++++++++++
 tb/tb_dmem_responder.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// ----------------------------------------------------------------------------
// dmem_if -- request/response bus between an initiator and dmem_responder.
//
// Request channel (initiator -> responder):
//   req_valid  request present
//   req_ready  responder can accept a request
//   req_write  1 = store, 0 = load
//   req_byte   1 = byte access, 0 = word access
//   req_addr   byte address
//   req_wdata  store data (byte stores use bits [7:0])
//
// Response channel (responder -> initiator):
//   rsp_valid  response present
//   rsp_ready  initiator accepts the response
//   rsp_rdata  load data (byte loads sign-extended, 0 for stores)
//   rsp_err    access rejected
//
// Modports: master = initiator side, slave = responder side.
// ----------------------------------------------------------------------------
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_byte;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_byte, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_byte, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface : dmem_if

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder -- single-outstanding data-memory responder.
//
// Accepts one load/store request at a time, waits WAIT_CYCLES extra cycles,
// performs the access on an internal byte array (big-endian words) and holds
// the response until the initiator takes it.
//
// Parameters:
//   WAIT_CYCLES  extra wait states between accept and response (0..15)
//   MEM_BYTES    byte capacity of the internal array (power of two, >= 4)
//
// Ports:
//   clk  single clock, all state changes on the rising edge
//   rst  synchronous, active-high reset (clears FSM, response and array)
//   bus  dmem_if.slave request/response bus
//
// Build option:
//   DMEM_ALIGN_CHECK_EN  when defined, word accesses with addr[1:0] != 0
//                        complete with rsp_err=1, rsp_rdata=0 and no store.
//                        When undefined, addr[1:0] is ignored for word
//                        accesses and rsp_err is always 0.
// ----------------------------------------------------------------------------
module dmem_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int MEM_BYTES   = 1024
) (
  input  logic   clk,
  input  logic   rst,
  dmem_if.slave  bus
);

  localparam int         AW        = $clog2(MEM_BYTES);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;

  // Request fields captured at accept time
  logic            wr_q;
  logic            byte_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     wdata_q;

  // Registered response
  logic [31:0]     rdata_q;
  logic            err_q;

  logic [7:0]      mem [MEM_BYTES];

  logic            accept;
  logic            exec_en;

  // Operands of the access being executed this cycle
  logic            x_write;
  logic            x_byte;
  logic [AW-1:0]   x_addr;
  logic [31:0]     x_wdata;
  logic            x_err;
  logic [AW-1:0]   lane0, lane1, lane2, lane3;
  logic [7:0]      byte_val;
  logic [31:0]     word_val;
  logic [31:0]     load_data;
  logic [31:0]     rsp_data_d;

  // --------------------------------------------------------------------------
  // FSM next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    exec_en = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          accept = 1'b1;
          cnt_d  = WAIT_INIT;
          if (WAIT_CYCLES == 0) begin
            // No wait states: the access runs on the accept edge itself.
            exec_en = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end

      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // The counter reaches zero on this edge: execute and respond.
        if (cnt_q == 4'd1) begin
          exec_en = 1'b1;
          state_d = RESP;
        end
      end

      RESP: begin
        // Completion cycle returns to IDLE; req_ready only rises afterwards.
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM state, counter and request capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      byte_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q    <= bus.req_write;
        byte_q  <= bus.req_byte;
        addr_q  <= bus.req_addr[AW-1:0];
        wdata_q <= bus.req_wdata;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Access datapath
  // --------------------------------------------------------------------------
  // With no wait states the access executes on the accept edge, so it must
  // see the live request; otherwise it uses the captured copy.
  assign x_write = (WAIT_CYCLES == 0) ? bus.req_write           : wr_q;
  assign x_byte  = (WAIT_CYCLES == 0) ? bus.req_byte            : byte_q;
  assign x_addr  = (WAIT_CYCLES == 0) ? bus.req_addr[AW-1:0]    : addr_q;
  assign x_wdata = (WAIT_CYCLES == 0) ? bus.req_wdata           : wdata_q;

`ifdef DMEM_ALIGN_CHECK_EN
  assign x_err = !x_byte && (x_addr[1:0] != 2'b00);
`else
  assign x_err = 1'b0;
`endif

  // Word lanes, big-endian: lane0 holds bits [31:24]. The low two address
  // bits are dropped so a word never straddles an aligned boundary.
  assign lane0 = {x_addr[AW-1:2], 2'd0};
  assign lane1 = {x_addr[AW-1:2], 2'd1};
  assign lane2 = {x_addr[AW-1:2], 2'd2};
  assign lane3 = {x_addr[AW-1:2], 2'd3};

  assign byte_val  = mem[x_addr];
  assign word_val  = {mem[lane0], mem[lane1], mem[lane2], mem[lane3]};
  assign load_data = x_byte ? {{24{byte_val[7]}}, byte_val} : word_val;

  // Stores and rejected accesses return zero data.
  assign rsp_data_d = (x_write || x_err) ? 32'd0 : load_data;

  // --------------------------------------------------------------------------
  // Response registers
  // --------------------------------------------------------------------------
  // Read data is captured on the execute edge, before the store of the same
  // access lands, so a load always sees the pre-transaction contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (exec_en) begin
      rdata_q <= rsp_data_d;
      err_q   <= x_err;
    end
  end

  // --------------------------------------------------------------------------
  // Byte array
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the array must read as zero after reset, so it is built from
      // resettable flops rather than a RAM macro without a clear.
      for (int i = 0; i < MEM_BYTES; i++) begin
        mem[i] <= '0;
      end
    end else if (exec_en && x_write && !x_err) begin
      if (x_byte) begin
        mem[x_addr] <= x_wdata[7:0];
      end else begin
        mem[lane0] <= x_wdata[31:24];
        mem[lane1] <= x_wdata[23:16];
        mem[lane2] <= x_wdata[15:8];
        mem[lane3] <= x_wdata[7:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  // Both handshake outputs depend on the state register only, never on
  // req_valid or rsp_ready.
  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule : dmem_responder

// File: tb/tb_dmem_responder.sv
// ----------------------------------------------------------------------------
// tb_dmem_responder -- scoreboard bench for dmem_responder.
//
// A driver issues requests and pushes the reference model's expected
// response into a queue; an independent monitor pops and compares each time
// the DUT presents a response, and randomly back-pressures rsp_ready.
// A second instance with WAIT_CYCLES=0 is exercised back-to-back.
// Honours DMEM_ALIGN_CHECK_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_dmem_responder;

  localparam int W   = 2;
  localparam int MEM = 1024;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_if bus ();
  dmem_if bus0 ();

  dmem_responder #(.WAIT_CYCLES(W), .MEM_BYTES(MEM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  dmem_responder #(.WAIT_CYCLES(0), .MEM_BYTES(MEM)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  exp_t exp_q [$];
  logic [7:0] mdl [MEM];

  // Monitor state
  bit          active     = 0;
  bit          completing = 0;
  int          hold       = 0;
  int          force_hold = -1;
  logic [31:0] held_rdata;
  logic        held_err;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: byte array, big-endian words, address wrap.
  // --------------------------------------------------------------------------
  function automatic void model_clear();
    for (int i = 0; i < MEM; i++) mdl[i] = 8'h00;
  endfunction

  function automatic void model_access(input logic wr, input logic by,
                                       input logic [31:0] a, input logic [31:0] wd,
                                       output logic [31:0] rd, output logic err);
    int idx;
    idx = int'(a % MEM);
    rd  = 32'd0;
    err = 1'b0;
    if (by) begin
      if (wr) mdl[idx] = wd[7:0];
      else    rd = {{24{mdl[idx][7]}}, mdl[idx]};
      return;
    end
`ifdef DMEM_ALIGN_CHECK_EN
    if (idx % 4 != 0) begin
      err = 1'b1;
      return;
    end
`endif
    idx = idx - (idx % 4);
    if (wr) begin
      for (int k = 0; k < 4; k++) mdl[idx + k] = wd[31 - 8*k -: 8];
    end else begin
      rd = {mdl[idx], mdl[idx + 1], mdl[idx + 2], mdl[idx + 3]};
    end
  endfunction

  // --------------------------------------------------------------------------
  // Driver
  // --------------------------------------------------------------------------
  task automatic do_req(input logic wr, input logic by, input logic [31:0] a,
                        input logic [31:0] wd, input bit expect_rsp);
    int          n = 0;
    logic [31:0] rd;
    logic        er;
    @(negedge clk);
    while (!bus.req_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      check("req_ready_timeout", bus.req_ready, 1);
      return;
    end
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_byte  = by;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    if (expect_rsp) begin
      model_access(wr, by, a, wd, rd, er);
      exp_q.push_back('{rdata: rd, err: er, acc: cyc});
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || active || completing) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", (exp_q.size() == 0 && !active && !completing), 1);
  endtask

  // --------------------------------------------------------------------------
  // Monitor: pops expectations, checks stability, drives rsp_ready.
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    if (rst) begin
      active         = 0;
      completing     = 0;
      bus.rsp_ready  = 1'b0;
    end else if (completing) begin
      check("rsp_valid_drop", bus.rsp_valid, 0);
      check("req_ready_back", bus.req_ready, 1);
      completing    = 0;
      active        = 0;
      bus.rsp_ready = 1'b0;
    end else if (bus.rsp_valid) begin
      if (!active) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", bus.rsp_valid, 0);
          hold = 0;
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("rsp_rdata", bus.rsp_rdata, e.rdata);
          check("rsp_err", bus.rsp_err, e.err);
          check("rsp_latency", cyc - e.acc, W + 1);
          hold = (force_hold >= 0) ? force_hold : int'($urandom_range(0, 3));
        end
        held_rdata = bus.rsp_rdata;
        held_err   = bus.rsp_err;
        active     = 1;
      end else begin
        check("hold_rdata", bus.rsp_rdata, held_rdata);
        check("hold_err", bus.rsp_err, held_err);
        check("hold_req_ready", bus.req_ready, 0);
      end
      if (hold == 0) begin
        bus.rsp_ready = 1'b1;
        completing    = 1;
      end else begin
        hold--;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Back-to-back stimulus for the zero-wait instance
  // --------------------------------------------------------------------------
  logic        b2b_wr   [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
  logic        b2b_by   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [31:0] b2b_addr [4] = '{32'h4, 32'h4, 32'h7, 32'h4};
  logic [31:0] b2b_exp  [4] = '{32'h0, 32'hA5A50001, 32'h00000001, 32'hFFFFFFA5};

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_byte   = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus0.req_valid = 1'b0;
    bus0.req_write = 1'b0;
    bus0.req_byte  = 1'b0;
    bus0.req_addr  = '0;
    bus0.req_wdata = '0;
    bus0.rsp_ready = 1'b1;
    model_clear();

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_req_ready", bus.req_ready, 1);
    check("reset_rsp_valid", bus.rsp_valid, 0);
    check("reset_rsp_rdata", bus.rsp_rdata, 0);
    check("reset_rsp_err", bus.rsp_err, 0);

    // Load from a freshly cleared array
    do_req(1'b0, 1'b0, 32'h000, 32'h0, 1);

    // Big-endian word store, sign-extended byte loads
    do_req(1'b1, 1'b0, 32'h010, 32'hDEADBEEF, 1);
    do_req(1'b0, 1'b1, 32'h010, 32'h0, 1);
    do_req(1'b0, 1'b1, 32'h013, 32'h0, 1);

    // Long back-pressure on the response
    drain();
    force_hold = 5;
    do_req(1'b0, 1'b0, 32'h010, 32'h0, 1);
    drain();
    force_hold = -1;

    // Misaligned word store above the array size
    do_req(1'b1, 1'b0, 32'h402, 32'h12345678, 1);
    do_req(1'b0, 1'b0, 32'h000, 32'h0, 1);
    do_req(1'b0, 1'b0, 32'h400, 32'h0, 1);

    // Random traffic over a small, aliased address window
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) << 10) | $urandom_range(0, 47);
      do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom(), 1);
    end

    // Reset in the middle of a store: transaction aborted, array cleared
    drain();
    do_req(1'b1, 1'b0, 32'h020, 32'h11223344, 1);
    do_req(1'b0, 1'b0, 32'h020, 32'h0, 1);
    drain();
    do_req(1'b1, 1'b0, 32'h020, 32'hCAFEF00D, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    exp_q.delete();
    check("abort_rsp_valid", bus.rsp_valid, 0);
    check("abort_req_ready", bus.req_ready, 1);
    check("abort_rsp_rdata", bus.rsp_rdata, 0);
    check("abort_rsp_err", bus.rsp_err, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_rsp", bus.rsp_valid, 0);
    end
    do_req(1'b0, 1'b0, 32'h020, 32'h0, 1);
    do_req(1'b0, 1'b1, 32'h013, 32'h0, 1);
    drain();

    // Zero wait states, request held valid continuously, rsp_ready tied high:
    // IDLE and RESP alternate, each response one cycle after its accept.
    @(negedge clk);
    bus0.req_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("b2b_req_ready", bus0.req_ready, (i % 2 == 0));
      check("b2b_rsp_valid", bus0.rsp_valid, (i % 2 == 1));
      if (i % 2 == 1) begin
        check("b2b_rdata", bus0.rsp_rdata, b2b_exp[i / 2]);
      end else begin
        bus0.req_write = b2b_wr[i / 2];
        bus0.req_byte  = b2b_by[i / 2];
        bus0.req_addr  = b2b_addr[i / 2];
        bus0.req_wdata = 32'hA5A50001;
      end
      @(negedge clk);
    end
    bus0.req_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog");
  end

endmodule : tb_dmem_responder
